// File: rtl/store_buffer.sv
// Write-side store buffer: absorbs committed stores, drains them to the data
// cache when the port is free, and forwards buffered data to younger loads.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StoreM,
  input  logic              LoadM,
  input  logic [AW-1:0]     AddrM,
  input  logic [DW-1:0]     WDataM,
  input  logic [DW/8-1:0]   ByteEnM,
  input  logic              dCacheStall,
  output logic              SBStall,
  output logic              LoadHitM,
  output logic [DW-1:0]     LoadDataM,
  output logic              SBEmpty,
  output logic              sb_wr_valid,
  output logic [AW-1:0]     sb_wr_addr,
  output logic [DW-1:0]     sb_wr_data,
  output logic [DW/8-1:0]   sb_wr_be,
  input  logic              sb_wr_ready
);

  localparam int unsigned BW  = DW / 8;
  localparam int unsigned WAW = AW - 2;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  logic [DEPTH-1:0] valid_q;
  logic [WAW-1:0]   waddr_q [DEPTH];
  logic [DW-1:0]    data_q  [DEPTH];
  logic [BW-1:0]    be_q    [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  state_e        state_q, state_d;
  logic          wr_valid_q, wr_valid_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [BW-1:0] wr_be_q, wr_be_d;

  logic          full_c, enq_c, pop_c;
  logic          fwd_match_c, cover_c;
  logic [PW-1:0] fwd_idx_c, scan_idx_c;
  logic          unused_addr_lo;

  assign unused_addr_lo = ^AddrM[1:0];

  assign full_c = (count_q == CW'(DEPTH));
  assign enq_c  = StoreM & ~dCacheStall & ~full_c;
  assign pop_c  = wr_valid_q & sb_wr_ready;

  // Pointer and occupancy bookkeeping
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_c) tail_d = tail_q + PW'(1);
    if (pop_c) head_d = head_q + PW'(1);
    case ({enq_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        data_q[i]  <= '0;
        be_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Enqueue and pop never target the same slot: that would need a full buffer
      if (pop_c) valid_q[head_q] <= 1'b0;
      if (enq_c) begin
        valid_q[tail_q] <= 1'b1;
        waddr_q[tail_q] <= AddrM[AW-1:2];
        data_q[tail_q]  <= WDataM;
        be_q[tail_q]    <= ByteEnM;
      end
    end
  end

  // Drain FSM: the head entry is latched onto the cache port and held until accepted
  always_comb begin
    state_d    = state_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_be_d    = wr_be_q;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !LoadM) begin
          state_d    = S_ISSUE;
          wr_valid_d = 1'b1;
          wr_addr_d  = {waddr_q[head_q], 2'b00};
          wr_data_d  = data_q[head_q];
          wr_be_d    = be_q[head_q];
        end
      end
      S_ISSUE: begin
        if (sb_wr_ready) begin
          state_d    = S_IDLE;
          wr_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        wr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_be_q    <= wr_be_d;
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest
  always_comb begin
    fwd_match_c = 1'b0;
    fwd_idx_c   = '0;
    scan_idx_c  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx_c = head_q + PW'(k);
      if (valid_q[scan_idx_c] && (waddr_q[scan_idx_c] == AddrM[AW-1:2])) begin
        fwd_match_c = 1'b1;
        fwd_idx_c   = scan_idx_c;
      end
    end
  end

  assign cover_c   = ((be_q[fwd_idx_c] & ByteEnM) == ByteEnM);
  assign LoadHitM  = LoadM & fwd_match_c & cover_c;
  assign LoadDataM = LoadHitM ? data_q[fwd_idx_c] : '0;
  assign SBStall   = (StoreM & full_c) | (LoadM & fwd_match_c & ~cover_c);
  assign SBEmpty   = (count_q == '0) && (state_q == S_IDLE);

  assign sb_wr_valid = wr_valid_q;
  assign sb_wr_addr  = wr_addr_q;
  assign sb_wr_data  = wr_data_q;
  assign sb_wr_be    = wr_be_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        StoreM, LoadM, dCacheStall, sb_wr_ready;
  logic [31:0] AddrM, WDataM;
  logic [3:0]  ByteEnM;
  logic        SBStall, LoadHitM, SBEmpty, sb_wr_valid;
  logic [31:0] LoadDataM, sb_wr_addr, sb_wr_data;
  logic [3:0]  sb_wr_be;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .StoreM(StoreM), .LoadM(LoadM), .AddrM(AddrM), .WDataM(WDataM),
    .ByteEnM(ByteEnM), .dCacheStall(dCacheStall),
    .SBStall(SBStall), .LoadHitM(LoadHitM), .LoadDataM(LoadDataM),
    .SBEmpty(SBEmpty), .sb_wr_valid(sb_wr_valid), .sb_wr_addr(sb_wr_addr),
    .sb_wr_data(sb_wr_data), .sb_wr_be(sb_wr_be), .sb_wr_ready(sb_wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t        mq[$];
  bit          m_infl;
  bit          last_enq;
  logic [31:0] dut_drained[$];
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model
  task automatic cycle();
    bit          e_hit, e_part, e_stall, pop, enq, nxt;
    logic [31:0] e_data;
    #4;
    e_hit = 0; e_part = 0; e_data = '0;
    if (LoadM) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].wa == AddrM[31:2]) begin
          if ((mq[i].be & ByteEnM) == ByteEnM) begin
            e_hit = 1; e_data = mq[i].d;
          end else begin
            e_part = 1;
          end
          break;
        end
      end
    end
    e_stall = (StoreM && mq.size() == DEPTH) || e_part;
    chk("SBStall", SBStall, e_stall);
    chk("LoadHitM", LoadHitM, e_hit);
    if (!e_part) chk("LoadDataM", LoadDataM, e_data);
    chk("SBEmpty", SBEmpty, (mq.size() == 0) && !m_infl);
    chk("sb_wr_valid", sb_wr_valid, m_infl);
    if (m_infl && mq.size() != 0) begin
      chk("sb_wr_addr", sb_wr_addr, {mq[0].wa, 2'b00});
      chk("sb_wr_data", sb_wr_data, mq[0].d);
      chk("sb_wr_be", sb_wr_be, mq[0].be);
    end
    if (sb_wr_valid && sb_wr_ready) dut_drained.push_back(sb_wr_addr);
    @(posedge clk);
    pop = m_infl && sb_wr_ready;
    enq = StoreM && !dCacheStall && (mq.size() != DEPTH);
    nxt = m_infl ? !sb_wr_ready : ((mq.size() != 0) && !LoadM);
    if (pop) void'(mq.pop_front());
    if (enq) mq.push_back('{wa: AddrM[31:2], d: WDataM, be: ByteEnM});
    last_enq = enq;
    m_infl   = nxt;
    #1;
  endtask

  task automatic idle_inputs();
    StoreM = 0; LoadM = 0; dCacheStall = 0;
    AddrM = '0; WDataM = '0; ByteEnM = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    StoreM = 1; LoadM = 0; AddrM = a; WDataM = d; ByteEnM = be;
    cycle();
    StoreM = 0;
  endtask

  task automatic drain_all();
    idle_inputs();
    sb_wr_ready = 1;
    for (int n = 0; n < 40 && (mq.size() != 0 || m_infl); n++) cycle();
    #1;
    chk("drain_empty", SBEmpty, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_SBStall"}, SBStall, 0);
    chk({tag, "_LoadHitM"}, LoadHitM, 0);
    chk({tag, "_LoadDataM"}, LoadDataM, 0);
    chk({tag, "_SBEmpty"}, SBEmpty, 1);
    chk({tag, "_valid"}, sb_wr_valid, 0);
    chk({tag, "_addr"}, sb_wr_addr, 0);
    chk({tag, "_data"}, sb_wr_data, 0);
    chk({tag, "_be"}, sb_wr_be, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_order [5];
    logic [31:0] held;
    checks = 0; failures = 0; m_infl = 0; last_enq = 0;
    rst = 1; sb_wr_ready = 0;
    idle_inputs();

    // Reset then idle
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 0;
    repeat (3) cycle();
    chk("idle_no_issue", sb_wr_valid, 0);

    // Single store drains two cycles after enqueue
    sb_wr_ready = 1;
    store(32'h100, 32'hDEADBEEF, 4'hF);
    cycle();
    chk("single_valid", sb_wr_valid, 1);
    chk("single_addr", sb_wr_addr, 32'h100);
    chk("single_data", sb_wr_data, 32'hDEADBEEF);
    cycle();
    chk("single_empty", SBEmpty, 1);

    // Fill to full, stall the fifth store, then release
    sb_wr_ready = 0;
    dut_drained.delete();
    for (int i = 0; i < 4; i++) store(32'(i * 4), 32'hA0 + 32'(i), 4'hF);
    StoreM = 1; AddrM = 32'h10; WDataM = 32'hA4; ByteEnM = 4'hF;
    #1;
    chk("full_stall", SBStall, 1);
    repeat (3) cycle();
    chk("full_stall_held", SBStall, 1);
    sb_wr_ready = 1;
    last_enq = 0;
    for (int n = 0; n < 20 && !last_enq; n++) cycle();
    chk("full_enq_done", last_enq, 1);
    drain_all();
    exp_order = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    chk("order_len", dut_drained.size(), 5);
    for (int i = 0; i < 5 && i < dut_drained.size(); i++) chk("order_addr", dut_drained[i], exp_order[i]);

    // Forwarding picks the youngest matching entry
    sb_wr_ready = 0;
    store(32'h200, 32'h11111111, 4'hF);
    store(32'h200, 32'h22222222, 4'hF);
    LoadM = 1; AddrM = 32'h200; ByteEnM = 4'hF;
    #1;
    chk("fwd_hit", LoadHitM, 1);
    chk("fwd_data", LoadDataM, 32'h22222222);
    cycle();
    AddrM = 32'h204;
    #1;
    chk("fwd_miss", LoadHitM, 0);
    chk("fwd_miss_data", LoadDataM, 0);
    cycle();
    drain_all();

    // Partial coverage stalls until the entry drains
    sb_wr_ready = 0;
    store(32'h300, 32'h000000AA, 4'h1);
    cycle();
    LoadM = 1; AddrM = 32'h300; ByteEnM = 4'hF;
    #1;
    chk("partial_stall", SBStall, 1);
    chk("partial_nohit", LoadHitM, 0);
    repeat (2) cycle();
    sb_wr_ready = 1;
    cycle();
    #1;
    chk("partial_released", SBStall, 0);
    chk("partial_after_hit", LoadHitM, 0);
    cycle();
    drain_all();

    // Port contention: loads hold off the drain, but not an issued write
    sb_wr_ready = 0;
    store(32'h500, 32'h55AA55AA, 4'hF);
    LoadM = 1; AddrM = 32'h600; ByteEnM = 4'hF;
    repeat (4) cycle();
    chk("contend_blocked", sb_wr_valid, 0);
    LoadM = 0;
    cycle();
    chk("contend_issue", sb_wr_valid, 1);
    chk("contend_addr", sb_wr_addr, 32'h500);
    held = sb_wr_data;
    LoadM = 1;
    repeat (3) cycle();
    chk("contend_held_valid", sb_wr_valid, 1);
    chk("contend_held_data", sb_wr_data, 32'h55AA55AA);
    chk("contend_stable", sb_wr_data, held);
    drain_all();

    // Reset mid-drain discards everything immediately
    sb_wr_ready = 0;
    store(32'h700, 32'h77777777, 4'hF);
    store(32'h704, 32'h88888888, 4'hF);
    cycle();
    idle_inputs();
    #2;
    rst = 1;
    #1;
    check_reset_outputs("midrst");
    mq.delete();
    m_infl = 0;
    @(posedge clk); #1;
    rst = 0;
    repeat (3) cycle();
    chk("midrst_no_issue", sb_wr_valid, 0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int op;
      op          = int'($urandom_range(0, 3));
      StoreM      = (op == 0);
      LoadM       = (op == 1);
      AddrM       = 32'h400 + 32'($urandom_range(0, 3)) * 4;
      WDataM      = $urandom;
      ByteEnM     = 4'($urandom_range(1, 15));
      dCacheStall = ($urandom_range(0, 9) == 0);
      sb_wr_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    drain_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
